// File: rtl/shoot_pkg.sv
//------------------------------------------------------------------------------
// Module  : shoot_pkg
// Brief   : Shared constants, types and helpers for the shooter game blocks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shoot_pkg;

  // Display geometry and bullet sprite size
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BULLET_WIDTH  = 6;
  localparam int BULLET_HEIGHT = 20;

  // Packed position {x, y} field widths
  localparam int POS_X_W = 10;
  localparam int POS_Y_W = 9;
  localparam int POS_W   = POS_X_W + POS_Y_W;

  // Cooldown counter width, wide enough for the longest phase period
  localparam int COOL_W = 7;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2
  } fsm_state_t;

  // Fire period in ticks for each difficulty phase; later phases fire faster
  function automatic logic [COOL_W-1:0] phase_period(input logic [1:0] phase);
    case (phase)
      2'd0:    return 7'd64;
      2'd1:    return 7'd32;
      2'd2:    return 7'd16;
      default: return 7'd8;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : enemy_rr_arbiter
// Brief   : Round-robin arbiter; searches the request mask starting one past
//           the pointer and returns a one-hot grant plus its index.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module enemy_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_Req,
  input  logic [IW-1:0] i_Ptr,
  output logic [N-1:0]  o_Grant,
  output logic [IW-1:0] o_Idx,
  output logic          o_Any
);

  // First requester found walking forward from (pointer + 1) with wrap
  always_comb begin
    int   j;
    logic found;
    j       = 0;
    found   = 1'b0;
    o_Grant = '0;
    o_Idx   = '0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(i_Ptr) + i) % N;
      if (!found && i_Req[j]) begin
        found      = 1'b1;
        o_Grant[j] = 1'b1;
        o_Idx      = IW'(j);
      end
    end
    o_Any = found;
  end

endmodule

`default_nettype wire

// File: rtl/enemy_fire_scheduler.sv
//------------------------------------------------------------------------------
// Module  : enemy_fire_scheduler
// Brief   : Decides when and from which enemies bullets are fired, picks a free
//           bullet-pool slot for each, and hands spawn requests to the bullet
//           datapath over a valid/ready interface.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module enemy_fire_scheduler
  import shoot_pkg::*;
#(
  parameter int MAX_ENEMY = 4,
  parameter int MAX_SLOT  = 8,
  parameter int PHASE_LEN = 128,
  parameter int X_OFFSET  = 13,
  parameter int Y_OFFSET  = 24,
  parameter int V_BORDER  = 460
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Tick,
  input  logic                           i_Enable,
  input  logic [MAX_ENEMY-1:0]           i_EnemyAlive,
  input  logic [POS_W*MAX_ENEMY-1:0]     i_EnemyPos,
  input  logic [MAX_SLOT-1:0]            i_SlotFree,
  output logic                           o_SpawnValid,
  input  logic                           i_SpawnReady,
  output logic [$clog2(MAX_SLOT)-1:0]    o_SpawnSlot,
  output logic [POS_W-1:0]               o_SpawnPos,
  output logic [$clog2(MAX_ENEMY)-1:0]   o_SpawnEnemy,
  output logic [1:0]                     o_Phase,
  output logic                           o_Drop
);

  localparam int EW = $clog2(MAX_ENEMY);
  localparam int SW = $clog2(MAX_SLOT);
  localparam int TW = $clog2(PHASE_LEN);

  fsm_state_t           state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [COOL_W-1:0]    cool_q, cool_d;
  logic [EW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [MAX_ENEMY-1:0] pending_q, pending_d;
  logic [MAX_SLOT-1:0]  reserved_q, reserved_d;
  logic                 valid_q, valid_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [EW-1:0]        enemy_q, enemy_d;
  logic                 drop_q, drop_d;

  logic                 counted;
  logic                 fire;
  logic [MAX_ENEMY-1:0] pending_live;
  logic [MAX_ENEMY-1:0] arb_req;
  logic [MAX_ENEMY-1:0] arb_grant;
  logic [EW-1:0]        arb_idx;
  logic                 arb_any;
  logic [MAX_SLOT-1:0]  slot_avail;
  logic [SW-1:0]        slot_idx;
  logic                 slot_found;
  logic [POS_W-1:0]     src_pos;
  logic [POS_X_W:0]     x_sum;
  logic [POS_Y_W:0]     y_sum;
  logic                 pos_illegal;

  assign counted      = i_Tick & i_Enable;
  assign fire         = counted && (cool_q == COOL_W'(1));
  assign pending_live = pending_q & i_EnemyAlive;

  // In IDLE the arbiter picks among alive enemies for the one-hot wave load;
  // in SELECT it walks the outstanding pending set.
  assign arb_req = (state_q == ST_IDLE) ? i_EnemyAlive : pending_live;

  enemy_rr_arbiter #(
    .N  (MAX_ENEMY),
    .IW (EW)
  ) u_rr_arbiter (
    .i_Req   (arb_req),
    .i_Ptr   (rr_ptr_q),
    .o_Grant (arb_grant),
    .o_Idx   (arb_idx),
    .o_Any   (arb_any)
  );

  // Spawn position of the granted enemy; a carry out of either field or a y
  // at/below the border makes the shot illegal
  assign src_pos     = i_EnemyPos[POS_W*int'(arb_idx) +: POS_W];
  assign x_sum       = {1'b0, src_pos[POS_W-1:POS_Y_W]} + (POS_X_W+1)'(X_OFFSET);
  assign y_sum       = {1'b0, src_pos[POS_Y_W-1:0]} + (POS_Y_W+1)'(Y_OFFSET);
  assign pos_illegal = x_sum[POS_X_W] | y_sum[POS_Y_W] |
                       (int'(y_sum[POS_Y_W-1:0]) >= V_BORDER);

  assign slot_avail = i_SlotFree & ~reserved_q;

  // Lowest-index free, unreserved slot
  always_comb begin
    slot_idx   = '0;
    slot_found = |slot_avail;
    for (int i = MAX_SLOT - 1; i >= 0; i--) begin
      if (slot_avail[i]) slot_idx = SW'(i);
    end
  end

  // Tick, phase and cooldown counters; only enabled frame ticks advance them
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    cool_d     = cool_q;
    if (counted) begin
      if (tick_cnt_q == TW'(PHASE_LEN - 1)) begin
        tick_cnt_d = '0;
        phase_d    = phase_q + 2'd1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
      // Reload with the period of the phase in effect after this tick
      if (cool_q == COOL_W'(1)) cool_d = phase_period(phase_d);
      else                      cool_d = cool_q - 1'b1;
    end
  end

  // Wave FSM next state and registered spawn payload
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_live;
    reserved_d = reserved_q;
    rr_ptr_d   = rr_ptr_q;
    valid_d    = valid_q;
    slot_d     = slot_q;
    pos_d      = pos_q;
    enemy_d    = enemy_q;
    drop_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire && arb_any) begin
          state_d   = ST_SELECT;
          pending_d = phase_q[1] ? i_EnemyAlive : arb_grant;
        end
      end
      ST_SELECT: begin
        if (!arb_any) begin
          state_d    = ST_IDLE;
          reserved_d = '0;
        end else if (slot_found && !pos_illegal) begin
          state_d = ST_ISSUE;
          valid_d = 1'b1;
          slot_d  = slot_idx;
          pos_d   = {x_sum[POS_X_W-1:0], y_sum[POS_Y_W-1:0]};
          enemy_d = arb_idx;
        end else begin
          drop_d    = 1'b1;
          pending_d = pending_live & ~arb_grant;
        end
      end
      ST_ISSUE: begin
        if (i_SpawnReady) begin
          state_d    = ST_SELECT;
          valid_d    = 1'b0;
          pending_d  = pending_live & ~(MAX_ENEMY'(1) << enemy_q);
          reserved_d = reserved_q | (MAX_SLOT'(1) << slot_q);
          rr_ptr_d   = enemy_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= 2'd0;
      tick_cnt_q <= '0;
      cool_q     <= phase_period(2'd0);
      rr_ptr_q   <= EW'(MAX_ENEMY - 1);
      pending_q  <= '0;
      reserved_q <= '0;
      valid_q    <= 1'b0;
      slot_q     <= '0;
      pos_q      <= '0;
      enemy_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      cool_q     <= cool_d;
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      reserved_q <= reserved_d;
      valid_q    <= valid_d;
      slot_q     <= slot_d;
      pos_q      <= pos_d;
      enemy_q    <= enemy_d;
      drop_q     <= drop_d;
    end
  end

  assign o_SpawnValid = valid_q;
  assign o_SpawnSlot  = slot_q;
  assign o_SpawnPos   = pos_q;
  assign o_SpawnEnemy = enemy_q;
  assign o_Phase      = phase_q;
  assign o_Drop       = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_enemy_fire_scheduler
// Brief   : Directed self-checking bench for enemy_fire_scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_enemy_fire_scheduler;

  localparam int NE = 4;
  localparam int NS = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           i_Tick = 1'b0;
  logic           i_Enable = 1'b0;
  logic [NE-1:0]  i_EnemyAlive = '0;
  logic [19*NE-1:0] i_EnemyPos;
  logic [NS-1:0]  i_SlotFree = '0;
  logic           i_SpawnReady = 1'b0;
  logic           o_SpawnValid;
  logic [2:0]     o_SpawnSlot;
  logic [18:0]    o_SpawnPos;
  logic [1:0]     o_SpawnEnemy;
  logic [1:0]     o_Phase;
  logic           o_Drop;

  logic [9:0] ex [NE];
  logic [8:0] ey [NE];

  int n_checks = 0;
  int n_fail   = 0;

  int          q_enemy [$];
  int          q_slot  [$];
  logic [18:0] q_pos   [$];
  int          drop_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    i_EnemyPos = '0;
    for (int k = 0; k < NE; k++) i_EnemyPos[19*k +: 19] = {ex[k], ey[k]};
  end

  enemy_fire_scheduler dut (
    .i_Clk        (clk),
    .i_Rst        (rst_n),
    .i_Tick       (i_Tick),
    .i_Enable     (i_Enable),
    .i_EnemyAlive (i_EnemyAlive),
    .i_EnemyPos   (i_EnemyPos),
    .i_SlotFree   (i_SlotFree),
    .o_SpawnValid (o_SpawnValid),
    .i_SpawnReady (i_SpawnReady),
    .o_SpawnSlot  (o_SpawnSlot),
    .o_SpawnPos   (o_SpawnPos),
    .o_SpawnEnemy (o_SpawnEnemy),
    .o_Phase      (o_Phase),
    .o_Drop       (o_Drop)
  );

  // Record accepted spawns and drop pulses, sampled mid-low-phase
  always @(negedge clk) begin
    #1;
    if (rst_n && o_SpawnValid && i_SpawnReady) begin
      q_enemy.push_back(int'(o_SpawnEnemy));
      q_slot.push_back(int'(o_SpawnSlot));
      q_pos.push_back(o_SpawnPos);
    end
    if (rst_n && o_Drop) drop_cnt++;
  end

  function automatic logic [18:0] exp_pos(input int k);
    logic [9:0] x;
    logic [8:0] y;
    x = ex[k] + 10'd13;
    y = ey[k] + 9'd24;
    return {x, y};
  endfunction

  task automatic clear_log();
    q_enemy.delete();
    q_slot.delete();
    q_pos.delete();
    drop_cnt = 0;
  endtask

  task automatic do_reset();
    i_Tick = 1'b0;
    i_SpawnReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic do_tick();
    @(negedge clk);
    i_Tick = 1'b1;
    @(negedge clk);
    i_Tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) do_tick();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic default_inputs();
    for (int k = 0; k < NE; k++) begin
      ex[k] = 10'(100 + 50*k);
      ey[k] = 9'(50 + 10*k);
    end
    i_EnemyAlive = 4'b1111;
    i_SlotFree   = 8'hFF;
    i_Enable     = 1'b1;
    i_SpawnReady = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_SpawnValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_SpawnValid); end
    n_checks++; if (o_Phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", o_Phase); end
    n_checks++; if (o_Drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", o_Drop); end
    n_checks++; if (o_SpawnSlot !== 3'd0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", o_SpawnSlot); end
    n_checks++; if (o_SpawnPos !== 19'd0) begin n_fail++; $display("FAIL reset_pos: got %h want 0", o_SpawnPos); end
    n_checks++; if (o_SpawnEnemy !== 2'd0) begin n_fail++; $display("FAIL reset_enemy: got %0d want 0", o_SpawnEnemy); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_first_fire();
    default_inputs();
    tick_n(63);
    n_checks++; if (q_enemy.size() !== 0 || o_SpawnValid !== 1'b0) begin n_fail++; $display("FAIL early_fire: spawns %0d valid %b want 0/0", q_enemy.size(), o_SpawnValid); end
    do_tick();
    n_checks++; if (o_SpawnValid !== 1'b0) begin n_fail++; $display("FAIL latency_1: valid %b want 0", o_SpawnValid); end
    @(negedge clk);
    n_checks++; if (o_SpawnValid !== 1'b1) begin n_fail++; $display("FAIL latency_2: valid %b want 1", o_SpawnValid); end
    n_checks++; if (o_SpawnEnemy !== 2'd0 || o_SpawnSlot !== 3'd0) begin n_fail++; $display("FAIL first_grant: enemy %0d slot %0d want 0/0", o_SpawnEnemy, o_SpawnSlot); end
    n_checks++; if (o_SpawnPos !== exp_pos(0)) begin n_fail++; $display("FAIL first_pos: got %h want %h", o_SpawnPos, exp_pos(0)); end
    idle(3);
    n_checks++; if (q_enemy.size() !== 1 || o_SpawnValid !== 1'b0) begin n_fail++; $display("FAIL single_spawn: spawns %0d valid %b want 1/0", q_enemy.size(), o_SpawnValid); end
    tick_n(63);
    n_checks++; if (q_enemy.size() !== 1) begin n_fail++; $display("FAIL reload_64: spawns %0d want 1", q_enemy.size()); end
    do_tick();
    idle(3);
    n_checks++; if (q_enemy.size() !== 2) begin n_fail++; $display("FAIL second_fire: spawns %0d want 2", q_enemy.size()); end
    n_checks++; if (o_Phase !== 2'd1) begin n_fail++; $display("FAIL phase_1: got %0d want 1", o_Phase); end
  endtask

  task automatic test_phase1_rr();
    tick_n(31);
    n_checks++; if (q_enemy.size() !== 2) begin n_fail++; $display("FAIL period_32_early: spawns %0d want 2", q_enemy.size()); end
    do_tick();
    idle(3);
    tick_n(32);
    idle(3);
    tick_n(32);
    idle(3);
    n_checks++; if (q_enemy.size() !== 5) begin n_fail++; $display("FAIL rr_count: spawns %0d want 5", q_enemy.size()); end
    else begin
      n_checks++; if (q_enemy[0] !== 0 || q_enemy[1] !== 1 || q_enemy[2] !== 2 || q_enemy[3] !== 3 || q_enemy[4] !== 0)
        begin n_fail++; $display("FAIL rr_order: got %0d %0d %0d %0d %0d want 0 1 2 3 0", q_enemy[0], q_enemy[1], q_enemy[2], q_enemy[3], q_enemy[4]); end
    end
  endtask

  task automatic test_phase2_slots();
    clear_log();
    i_SlotFree = 8'b0000_0101;
    tick_n(32);
    idle(3);
    n_checks++; if (o_Phase !== 2'd2) begin n_fail++; $display("FAIL phase_2: got %0d want 2", o_Phase); end
    n_checks++; if (q_enemy.size() !== 1 || q_enemy[0] !== 1 || q_slot[0] !== 0)
      begin n_fail++; $display("FAIL phase1_last_wave: spawns %0d want one from enemy 1 slot 0", q_enemy.size()); end
    clear_log();
    tick_n(16);
    idle(10);
    n_checks++; if (q_enemy.size() !== 2) begin n_fail++; $display("FAIL partial_spawns: got %0d want 2", q_enemy.size()); end
    else begin
      n_checks++; if (q_enemy[0] !== 2 || q_slot[0] !== 0 || q_enemy[1] !== 3 || q_slot[1] !== 2)
        begin n_fail++; $display("FAIL partial_grants: got e%0d/s%0d e%0d/s%0d want e2/s0 e3/s2", q_enemy[0], q_slot[0], q_enemy[1], q_slot[1]); end
    end
    n_checks++; if (drop_cnt !== 2) begin n_fail++; $display("FAIL partial_drops: got %0d want 2", drop_cnt); end
    clear_log();
    i_SlotFree = 8'hFF;
    tick_n(16);
    idle(12);
    n_checks++; if (q_slot.size() !== 4) begin n_fail++; $display("FAIL full_wave: spawns %0d want 4", q_slot.size()); end
    else begin
      n_checks++; if (q_slot[0] !== 0 || q_slot[1] !== 1 || q_slot[2] !== 2 || q_slot[3] !== 3 || q_enemy[0] !== 0 || q_enemy[3] !== 3)
        begin n_fail++; $display("FAIL reserved_cleared: slots %0d %0d %0d %0d want 0 1 2 3", q_slot[0], q_slot[1], q_slot[2], q_slot[3]); end
    end
  endtask

  task automatic test_stall();
    logic [18:0] pos_want;
    do_reset();
    default_inputs();
    i_SpawnReady = 1'b0;
    tick_n(64);
    @(negedge clk);
    pos_want = exp_pos(0);
    n_checks++; if (o_SpawnValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_rise: valid %b want 1", o_SpawnValid); end
    i_EnemyAlive = 4'b1110;
    ex[0] = 10'd300;
    i_Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (o_SpawnValid !== 1'b1 || o_SpawnEnemy !== 2'd0 || o_SpawnSlot !== 3'd0 || o_SpawnPos !== pos_want) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: valid %b enemy %0d slot %0d pos %h want 1 0 0 %h", i, o_SpawnValid, o_SpawnEnemy, o_SpawnSlot, o_SpawnPos, pos_want);
      end
      @(negedge clk);
    end
    i_SpawnReady = 1'b1;
    @(negedge clk);
    n_checks++; if (o_SpawnValid !== 1'b0) begin n_fail++; $display("FAIL stall_accept: valid %b want 0", o_SpawnValid); end
    n_checks++; if (q_pos.size() !== 1 || q_pos[0] !== pos_want) begin n_fail++; $display("FAIL stall_payload: spawns %0d want 1 at %h", q_pos.size(), pos_want); end
    i_Enable = 1'b1;
    i_EnemyAlive = 4'b1111;
    idle(3);
    n_checks++; if (q_pos.size() !== 1 || o_SpawnValid !== 1'b0) begin n_fail++; $display("FAIL stall_after: spawns %0d valid %b want 1/0", q_pos.size(), o_SpawnValid); end
  endtask

  task automatic test_illegal_pos();
    do_reset();
    default_inputs();
    i_EnemyAlive = 4'b0001;
    ex[0] = 10'd100;
    ey[0] = 9'd440;
    tick_n(64);
    idle(4);
    n_checks++; if (drop_cnt !== 1 || q_pos.size() !== 0) begin n_fail++; $display("FAIL y_border: drops %0d spawns %0d want 1/0", drop_cnt, q_pos.size()); end
    ex[0] = 10'd1020;
    ey[0] = 9'd50;
    tick_n(64);
    idle(4);
    n_checks++; if (drop_cnt !== 2 || q_pos.size() !== 0) begin n_fail++; $display("FAIL x_carry: drops %0d spawns %0d want 2/0", drop_cnt, q_pos.size()); end
    ex[0] = 10'd200;
    ey[0] = 9'd435;
    tick_n(32);
    idle(4);
    n_checks++; if (q_pos.size() !== 1 || q_pos[0] !== {10'd213, 9'd459}) begin n_fail++; $display("FAIL y_edge_legal: spawns %0d want 1 at %h", q_pos.size(), {10'd213, 9'd459}); end
  endtask

  task automatic test_rr_dead();
    do_reset();
    default_inputs();
    i_EnemyAlive = 4'b1011;
    tick_n(64); idle(4);
    tick_n(64); idle(4);
    tick_n(32); idle(4);
    tick_n(32); idle(4);
    n_checks++; if (q_enemy.size() !== 4) begin n_fail++; $display("FAIL rr_dead_count: spawns %0d want 4", q_enemy.size()); end
    else begin
      n_checks++; if (q_enemy[0] !== 0 || q_enemy[1] !== 1 || q_enemy[2] !== 3 || q_enemy[3] !== 0)
        begin n_fail++; $display("FAIL rr_dead_order: got %0d %0d %0d %0d want 0 1 3 0", q_enemy[0], q_enemy[1], q_enemy[2], q_enemy[3]); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    default_inputs();
    i_Enable = 1'b0;
    tick_n(100);
    n_checks++; if (o_Phase !== 2'd0 || q_enemy.size() !== 0) begin n_fail++; $display("FAIL enable_freeze: phase %0d spawns %0d want 0/0", o_Phase, q_enemy.size()); end
    i_Enable = 1'b1;
    tick_n(63);
    idle(3);
    n_checks++; if (q_enemy.size() !== 0) begin n_fail++; $display("FAIL enable_count: spawns %0d want 0", q_enemy.size()); end
    do_tick();
    idle(3);
    n_checks++; if (q_enemy.size() !== 1) begin n_fail++; $display("FAIL enable_fire: spawns %0d want 1", q_enemy.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    default_inputs();
    i_SpawnReady = 1'b0;
    tick_n(64);
    @(negedge clk);
    n_checks++; if (o_SpawnValid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: valid %b want 1", o_SpawnValid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_SpawnValid !== 1'b0 || o_SpawnPos !== 19'd0) begin n_fail++; $display("FAIL async_reset: valid %b pos %h want 0/0", o_SpawnValid, o_SpawnPos); end
    i_SpawnReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    n_checks++; if (q_enemy.size() !== 0 || o_SpawnValid !== 1'b0) begin n_fail++; $display("FAIL reset_no_spawn: spawns %0d valid %b want 0/0", q_enemy.size(), o_SpawnValid); end
  endtask

  initial begin
    for (int k = 0; k < NE; k++) begin
      ex[k] = '0;
      ey[k] = '0;
    end
    test_reset();
    test_first_fire();
    test_phase1_rr();
    test_phase2_slots();
    test_stall();
    test_illegal_pos();
    test_rr_dead();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
